// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-expansion sequencer: streams round keys 0..NR over valid/ready,
// computing each next key combinationally from the registered current key.

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Forward AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX_TBL[{~in_i, 3'b000} +: 8];
endmodule

module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         done
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] NR_IDX = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_e         state_q, state_d;
  logic [127:0]   rk_data_q, rk_data_d;
  logic [3:0]     rk_idx_q, rk_idx_d;
  logic [7:0]     rcon_q, rcon_d;

  logic [31:0]    w0_s, w1_s, w2_s, w3_s;
  logic [31:0]    w4_s, w5_s, w6_s, w7_s;
  logic [31:0]    rot_s, sub_s, t_s;
  logic           last_s;

  assign w0_s  = rk_data_q[127:96];
  assign w1_s  = rk_data_q[95:64];
  assign w2_s  = rk_data_q[63:32];
  assign w3_s  = rk_data_q[31:0];
  assign rot_s = {w3_s[23:0], w3_s[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (rot_s[8*g +: 8]),
      .out_o (sub_s[8*g +: 8])
    );
  end

  assign t_s    = sub_s ^ {rcon_q, 24'h000000};
  assign w4_s   = w0_s ^ t_s;
  assign w5_s   = w1_s ^ w4_s;
  assign w6_s   = w2_s ^ w5_s;
  assign w7_s   = w3_s ^ w6_s;
  assign last_s = (rk_idx_q == NR_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rk_data_q <= 128'd0;
      rk_idx_q  <= 4'd0;
      rcon_q    <= 8'h01;
    end else begin
      state_q   <= state_d;
      rk_data_q <= rk_data_d;
      rk_idx_q  <= rk_idx_d;
      rcon_q    <= rcon_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_EMIT : S_IDLE;
      S_EMIT:  state_d = (rk_ready && last_s) ? S_DONE : S_EMIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Key/index/rcon only move on a load in IDLE or on a non-final handshake.
  always_comb begin
    rk_data_d = rk_data_q;
    rk_idx_d  = rk_idx_q;
    rcon_d    = rcon_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rk_data_d = key_in;
          rk_idx_d  = 4'd0;
          rcon_d    = 8'h01;
        end else begin
          rk_data_d = rk_data_q;
        end
      end
      S_EMIT: begin
        if (rk_ready && !last_s) begin
          rk_data_d = {w4_s, w5_s, w6_s, w7_s};
          rk_idx_d  = rk_idx_q + 4'd1;
          rcon_d    = xtime(rcon_q);
        end else begin
          rk_data_d = rk_data_q;
        end
      end
      default: rk_data_d = rk_data_q;
    endcase
  end

  always_comb begin
    busy     = (state_q != S_IDLE);
    rk_valid = (state_q == S_EMIT);
    done     = (state_q == S_DONE);
    rk_data  = rk_data_q;
    rk_idx   = rk_idx_q;
  end
endmodule
